oka_overlap_accum: RTL and testbench
====================================

// Module: oka_overlap_accum
// PURPOSE
//  Parametrised, pipelined recombination stage for GF(2) Karatsuba multipliers.
//  - Takes four (N-1)-bit partial products per beat and forms one (2N-1)-bit product.
//  - Two modes: overlap-free interleave or classic Karatsuba.
//  - Optionally XOR-accumulates several beats into one result, for multi-limb products.
//  - Sits between the sub-multiplier array and the reduction/output stage; valid/ready on both sides.
// PARAMETERS
//  N       64  operand width; even, >=4; partial products are N-1 bits, result 2N-1 bits
//  BEAT_W   8  width of per-transaction beat counter (saturating)
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      input beat valid
//  in_ready   out  1      input beat accepted when in_valid & in_ready
//  in_mode    in   1      0 = OVERLAP, 1 = CLASSIC
//  in_last    in   1      final beat of transaction
//  p1..p4     in   N-1    partial products (four ports)
//  out_valid  out  1      result valid
//  out_ready  in   1      downstream accepts when out_valid & out_ready
//  out_data   out  2N-1   accumulated product
//  out_beats  out  BEAT_W beats in transaction, saturates at 2^BEAT_W-1
// BEHAVIOUR
//  Combine, with spread(x) placing x[i] at bit 2i and zeros at odd bits:
//   - OVERLAP: c = spread(p1) ^ (spread(p2^p3)<<1) ^ (spread(p4)<<2).
//     So c[2i] = p1[i]^p4[i-1] and c[2i+1] = p2[i]^p3[i].
//     Out-of-range terms are 0, so c[2N-2] = p4[N-2].
//   - CLASSIC: p1=L, p2=M, p4=H, p3 ignored.
//     c = L ^ ((L^M^H)<<N/2) ^ (H<<N), truncated to 2N-1 bits.
//  Pipeline:
//   - S1 registers c, last and v1 on every accepted beat.
//   - S2 holds the accumulator acc, the open flag and the beat counter.
//  S2 advance (v1 & !stall2):
//   - r = (open ? acc : 0) ^ c_q; cnt = (open ? beats : 0) + 1, saturating.
//   - If last_q: out_data<=r, out_beats<=cnt, out_valid<=1, open<=0, acc<=0.
//   - Else: acc<=r, beats<=cnt, open<=1.
//  Stalls:
//   - stall2 = last_q & out_valid & !out_ready.
//   - A non-last beat never stalls.
//   - in_ready = !v1 | !stall2. This is combinational; no dependency on in_valid.
//  Output handshake:
//   - out_valid & out_ready with no new result clears out_valid.
//   - Same-cycle handoff with a new result keeps out_valid=1 and loads the new data.
//   - out_data/out_beats stay stable while out_valid & !out_ready.
//  Latency:
//   - Last beat accepted at edge t gives out_valid after edge t+1.
//   - Sustained throughput is one beat/cycle when out_ready=1.
//  Mode may differ per beat; each beat is combined in its own mode.
//  Reset (async, any time, incl. mid-transaction):
//   - v1, out_valid, open = 0; acc, out_data, out_beats, beats = 0.
//   - A partial transaction is discarded.
//  out_beats saturates; the accumulator is unaffected by saturation.
// STRUCTURE
//  Package oka_pkg: mode enum (OKA_OVERLAP=1'b0, OKA_CLASSIC=1'b1) and the spread function.
//  Sub-module oka_combine_core #(N): purely combinational mode mux (p1..p4, mode -> c).
//  Top holds S1/S2 registers, handshake and counter.
// TESTING (N=8)
//  OVERLAP, single beat, last=1:
//   - p1=7'h01, others 0 -> out_data=15'h0001, out_beats=1.
//   - p4=7'h40, others 0 -> 15'h4000.
//   - p2=7'h01, p3=7'h00 -> 15'h0002.
//   - p2=p3=7'h55 -> 15'h0000.
//  CLASSIC, single beat:
//   - L=7'h01 -> 15'h0011.
//   - H=7'h01 -> 15'h0110.
//   - M=7'h01 -> 15'h0010.
//   - p3=7'h7F alone -> 15'h0000.
//  Accumulate, OVERLAP:
//   - Beat1 p1=7'h01 last=0, beat2 p1=7'h03 last=1 -> one output 15'h0004, out_beats=2.
//   - No output after beat1.
//  Backpressure:
//   - out_ready=0; send three last=1 beats with p1=01,02,04.
//   - Third beat is not accepted (in_ready=0) while out_data=15'h0001 stays stable.
//   - Release out_ready -> outputs 0001, 0004, 0010 in order, none lost or duplicated.
//  Reset mid-transaction:
//   - Beat p1=7'h01 last=0, assert rst_n=0 for 1 cycle -> out_valid=0 immediately.
//   - Then single beat p1=7'h02 last=1 -> 15'h0004, out_beats=1.
//  Saturation, BEAT_W=2:
//   - Five beats p1=7'h01, last on fifth -> out_data=15'h0001, out_beats=3.

Source files
------------

// File: rtl/oka_pkg.sv
// Shared types and helpers for the GF(2) Karatsuba recombination stage.
// The spread helper works on a fixed maximum width; callers zero-extend and truncate.
package oka_pkg;

  typedef enum logic {
    OKA_OVERLAP = 1'b0,
    OKA_CLASSIC = 1'b1
  } oka_mode_e;

  // Largest operand width the spread helper covers.
  localparam int OKA_MAX_N = 512;

  // Places x[i] at bit 2i, leaving every odd bit zero.
  function automatic logic [2*OKA_MAX_N-1:0] oka_spread(input logic [OKA_MAX_N-1:0] x);
    logic [2*OKA_MAX_N-1:0] y;
    y = '0;
    for (int i = 0; i < OKA_MAX_N; i++) begin
      y[2*i] = x[i];
    end
    return y;
  endfunction

endpackage

// File: rtl/oka_combine_core.sv
// Combinational recombination of four partial products into one 2N-1 bit product.
// Zero latency; no flow control of its own.
module oka_combine_core
  import oka_pkg::*;
#(
  parameter int N = 64
) (
  input  logic [N-2:0]   p1,
  input  logic [N-2:0]   p2,
  input  logic [N-2:0]   p3,
  input  logic [N-2:0]   p4,
  input  oka_mode_e      mode,
  output logic [2*N-2:0] c
);

  localparam int W = 2*N - 1;
  localparam int M = OKA_MAX_N;

  logic [M-1:0]   x1, x23, x4;
  logic [2*M-1:0] s1, s23, s4;
  logic [W-1:0]   ovl, cls, l_w, m_w, h_w;
  logic           unused_hi;

  assign x1  = {{(M-N+1){1'b0}}, p1};
  assign x23 = {{(M-N+1){1'b0}}, p2 ^ p3};
  assign x4  = {{(M-N+1){1'b0}}, p4};

  assign s1  = oka_spread(x1);
  assign s23 = oka_spread(x23);
  assign s4  = oka_spread(x4);

  // Even bits carry p1 and the shifted p4, odd bits carry p2^p3.
  assign ovl = s1[W-1:0] ^ {s23[W-2:0], 1'b0} ^ {s4[W-3:0], 2'b00};

  // Classic: p1=L, p2=M, p4=H; p3 takes no part.
  assign l_w = {{N{1'b0}}, p1};
  assign m_w = {{N{1'b0}}, p1 ^ p2 ^ p4} << (N/2);
  assign h_w = {{N{1'b0}}, p4} << N;
  assign cls = l_w ^ m_w ^ h_w;

  assign c = (mode == OKA_CLASSIC) ? cls : ovl;

  // High spread bits are always zero for in-range inputs.
  assign unused_hi = ^{s1[2*M-1:W], s23[2*M-1:W-1], s4[2*M-1:W-2]};

endmodule

// File: rtl/oka_overlap_accum.sv
// Two-stage recombine + XOR-accumulate; last beat accepted at edge t is out_valid after t+1.
// Only a pending last beat facing a blocked output stalls; in_ready = !v1 | !stall2.
module oka_overlap_accum
  import oka_pkg::*;
#(
  parameter int N      = 64,
  parameter int BEAT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_mode,
  input  logic              in_last,
  input  logic [N-2:0]      p1,
  input  logic [N-2:0]      p2,
  input  logic [N-2:0]      p3,
  input  logic [N-2:0]      p4,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*N-2:0]    out_data,
  output logic [BEAT_W-1:0] out_beats
);

  localparam int W = 2*N - 1;

  oka_mode_e         mode;
  logic [W-1:0]      c, c_q, acc, r;
  logic              v1, last_q, open;
  logic [BEAT_W-1:0] beats, base, cnt;
  logic              stall2, adv;

  assign mode = oka_mode_e'(in_mode);

  oka_combine_core #(.N(N)) u_core (
    .p1   (p1),
    .p2   (p2),
    .p3   (p3),
    .p4   (p4),
    .mode (mode),
    .c    (c)
  );

  assign stall2   = last_q & out_valid & ~out_ready;
  assign in_ready = ~v1 | ~stall2;
  assign adv      = v1 & ~stall2;

  assign r    = (open ? acc : '0) ^ c_q;
  assign base = open ? beats : '0;
  assign cnt  = (&base) ? base : base + 1'b1;

  // S1: combined beat register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1     <= 1'b0;
      c_q    <= '0;
      last_q <= 1'b0;
    end else if (in_ready) begin
      v1 <= in_valid;
      if (in_valid) begin
        c_q    <= c;
        last_q <= in_last;
      end
    end
  end

  // S2: accumulator and output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      beats     <= '0;
      open      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_beats <= '0;
    end else begin
      if (adv && last_q) begin
        out_data  <= r;
        out_beats <= cnt;
        out_valid <= 1'b1;
        open      <= 1'b0;
        acc       <= '0;
      end else begin
        if (adv) begin
          acc   <= r;
          beats <= cnt;
          open  <= 1'b1;
        end
        if (out_valid && out_ready) begin
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_oka_overlap_accum.sv
// Directed bench for oka_overlap_accum at N=8, BEAT_W=2 with a result scoreboard.
module tb_oka_overlap_accum;

  localparam int N      = 8;
  localparam int BEAT_W = 2;

  typedef struct packed {
    logic [14:0] d;
    logic [1:0]  b;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid, in_ready, in_mode, in_last;
  logic [N-2:0]      p1, p2, p3, p4;
  logic              out_valid, out_ready;
  logic [2*N-2:0]    out_data;
  logic [BEAT_W-1:0] out_beats;

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];
  logic [14:0] m_acc = '0;
  logic [1:0]  m_cnt = '0;

  always #5 clk = ~clk;

  oka_overlap_accum #(.N(N), .BEAT_W(BEAT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_last   (in_last),
    .p1        (p1),
    .p2        (p2),
    .p3        (p3),
    .p4        (p4),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_beats (out_beats)
  );

  // Bit-level reference for one beat.
  function automatic logic [14:0] model(input logic mode, input logic [6:0] a, b, c, d);
    logic [14:0] r;
    r = '0;
    for (int i = 0; i < 7; i++) begin
      if (!mode) begin
        r[2*i]   = a[i];
        if (i > 0) r[2*i] = r[2*i] ^ d[i-1];
        r[2*i+1] = b[i] ^ c[i];
      end else begin
        r[i]   = r[i] ^ a[i];
        r[i+4] = r[i+4] ^ a[i] ^ b[i] ^ d[i];
        r[i+8] = r[i+8] ^ d[i];
      end
    end
    if (!mode) r[14] = d[6];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic drive(input logic mode, input logic last, input logic [6:0] a, b, c, d);
    in_valid = 1'b1;
    in_mode  = mode;
    in_last  = last;
    p1 = a; p2 = b; p3 = c; p4 = d;
  endtask

  task automatic wait_accept();
    int n;
    logic ok;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 100) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      n++;
    end
    chk("accept_timeout", {31'd0, ok}, 32'd1);
    @(posedge clk);
    #1;
    if (ok) begin
      m_acc = m_acc ^ model(in_mode, p1, p2, p3, p4);
      m_cnt = (m_cnt == 2'd3) ? m_cnt : m_cnt + 2'd1;
      if (in_last) begin
        exp_q.push_back('{d: m_acc, b: m_cnt});
        m_acc = '0;
        m_cnt = '0;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic send(input logic mode, input logic last, input logic [6:0] a, b, c, d);
    drive(mode, last, a, b, c, d);
    wait_accept();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk("drain_timeout", exp_q.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Output monitor: every handshake must match the oldest expected result.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", {17'd0, out_data}, 32'd0);
        checks++;
        errors++;
        $error("FAIL unexpected_output: observed data=%0h with no result expected", out_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_data", {17'd0, out_data}, {17'd0, e.d});
        chk("out_beats", {30'd0, out_beats}, {30'd0, e.b});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=no_finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_mode = 1'b0; in_last = 1'b0;
    p1 = '0; p2 = '0; p3 = '0; p4 = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data",  {17'd0, out_data},  32'd0);
    chk("rst_out_beats", {30'd0, out_beats}, 32'd0);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Overlap single beats, with a latency probe on the first
    send(1'b0, 1'b1, 7'h01, 7'h00, 7'h00, 7'h00);
    chk("lat_t0", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    chk("lat_t1", {31'd0, out_valid}, 32'd1);
    chk("lat_data", {17'd0, out_data}, 32'h0001);
    drain();
    send(1'b0, 1'b1, 7'h00, 7'h00, 7'h00, 7'h40);
    send(1'b0, 1'b1, 7'h00, 7'h01, 7'h00, 7'h00);
    send(1'b0, 1'b1, 7'h00, 7'h55, 7'h55, 7'h00);
    drain();
    chk("ovl_p4_top", {17'd0, model(1'b0, 7'h00, 7'h00, 7'h00, 7'h40)}, 32'h4000);

    // Classic single beats
    send(1'b1, 1'b1, 7'h01, 7'h00, 7'h00, 7'h00);
    send(1'b1, 1'b1, 7'h00, 7'h00, 7'h00, 7'h01);
    send(1'b1, 1'b1, 7'h00, 7'h01, 7'h00, 7'h00);
    send(1'b1, 1'b1, 7'h00, 7'h00, 7'h7F, 7'h00);
    send(1'b1, 1'b1, 7'h5A, 7'h33, 7'h11, 7'h6C);
    drain();

    // Accumulation: nothing emitted until the last beat
    send(1'b0, 1'b0, 7'h01, 7'h00, 7'h00, 7'h00);
    repeat (3) begin
      @(negedge clk);
      chk("acc_no_early_out", {31'd0, out_valid}, 32'd0);
    end
    @(posedge clk);
    #1;
    send(1'b0, 1'b1, 7'h03, 7'h00, 7'h00, 7'h00);
    drain();

    // Mixed modes in one transaction
    send(1'b1, 1'b0, 7'h01, 7'h00, 7'h00, 7'h00);
    send(1'b0, 1'b1, 7'h00, 7'h01, 7'h00, 7'h00);
    drain();

    // Backpressure: third last-beat held off while the first result sits
    out_ready = 1'b0;
    send(1'b0, 1'b1, 7'h01, 7'h00, 7'h00, 7'h00);
    send(1'b0, 1'b1, 7'h02, 7'h00, 7'h00, 7'h00);
    drive(1'b0, 1'b1, 7'h04, 7'h00, 7'h00, 7'h00);
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_out_stable", {17'd0, out_data}, 32'h0001);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_accept();
    drain();

    // Reset in the middle of a transaction discards it
    send(1'b0, 1'b0, 7'h01, 7'h00, 7'h00, 7'h00);
    rst_n = 1'b0;
    m_acc = '0;
    m_cnt = '0;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(1'b0, 1'b1, 7'h02, 7'h00, 7'h00, 7'h00);
    drain();

    // Beat counter saturation over five beats
    for (int i = 0; i < 5; i++) begin
      send(1'b0, (i == 4), 7'h01, 7'h00, 7'h00, 7'h00);
    end
    drain();

    // Back-to-back stream at full rate with random data
    for (int i = 0; i < 20; i++) begin
      send(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 7'($urandom), 7'($urandom),
           7'($urandom), 7'($urandom));
    end
    send(1'b0, 1'b1, 7'h11, 7'h22, 7'h33, 7'h44);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
